// File: rtl/sourcea_pkg.sv
// Shared types and helpers for the SourceA request arbiter.
package sourcea_pkg;

    localparam int TAG_W = 13;
    localparam int SET_W = 10;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [SET_W-1:0] set;
        logic [2:0]       param;
        logic             block;
    } a_req_t;

    // Ceiling log2, never below 1 so it is usable directly as a width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             found;
    logic [IDX_W-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= N; k++) begin
            j = IDX_W'((int'(ptr_i) + k) % N);
            if (!found && elig_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/source_a_arbiter.sv
// Round-robin sharing of the SourceA request port among MSHRs, with per-source
// single-outstanding tracking and a global in-flight credit limit.
module source_a_arbiter
    import sourcea_pkg::*;
#(
    parameter int N_REQ   = 8,
    parameter int SRC_W   = 3,
    parameter int TAG_W   = 13,
    parameter int SET_W   = 10,
    parameter int MAX_OUT = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*TAG_W-1:0]   req_tag_i,
    input  logic [N_REQ*SET_W-1:0]   req_set_i,
    input  logic [N_REQ*3-1:0]       req_param_i,
    input  logic [N_REQ-1:0]         req_block_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [TAG_W-1:0]         out_tag_o,
    output logic [SET_W-1:0]         out_set_o,
    output logic [2:0]               out_param_o,
    output logic                     out_block_o,
    output logic [SRC_W-1:0]         out_source_o,
    input  logic                     grant_valid_i,
    input  logic [SRC_W-1:0]         grant_source_i,
    output logic [N_REQ-1:0]         busy_mask_o,
    output logic [clog2(MAX_OUT+1)-1:0] inflight_o,
    output logic                     err_spurious_o
);

    localparam int PTR_W = clog2(N_REQ);
    localparam int IF_W  = clog2(MAX_OUT+1);

    a_req_t             reqs [N_REQ];
    a_req_t             out_q;
    logic [SRC_W-1:0]   src_q;
    logic               out_valid_q, err_q;
    logic [N_REQ-1:0]   busy_q, busy_d, elig, gnt, gmask;
    logic [PTR_W-1:0]   ptr_q, win;
    logic [IF_W-1:0]    inflight_q, inflight_d;
    logic               cap, gok;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign reqs[i] = {req_tag_i[i*TAG_W +: TAG_W], req_set_i[i*SET_W +: SET_W],
                          req_param_i[i*3 +: 3], req_block_i[i]};
    end

    rr_arbiter #(.N(N_REQ), .IDX_W(PTR_W)) u_rr (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (win)
    );

    assign elig = req_valid_i & ~busy_q;
    // Gated by reset so no requester sees an accept while the block is held in reset.
    assign cap  = reset_i & (~out_valid_q | out_ready_i)
                & (inflight_q < IF_W'(MAX_OUT)) & (|elig);
    assign req_ready_o = cap ? gnt : '0;

    // Sources >= N_REQ shift out of the mask and so read as not busy.
    assign gmask = N_REQ'(1) << grant_source_i;
    assign gok   = grant_valid_i & (|(gmask & busy_q));

    always_comb begin
        busy_d = busy_q;
        if (gok) busy_d = busy_d & ~gmask;
        if (cap) busy_d = busy_d | gnt;
        case ({cap, gok})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            out_valid_q <= 1'b0;
            busy_q      <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
            ptr_q       <= PTR_W'(N_REQ-1);
            out_q       <= '0;
            src_q       <= '0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            err_q      <= grant_valid_i & ~gok;
            if (cap) begin
                out_valid_q <= 1'b1;
                out_q       <= reqs[win];
                src_q       <= SRC_W'(win);
                ptr_q       <= win;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_tag_o      = out_q.tag;
    assign out_set_o      = out_q.set;
    assign out_param_o    = out_q.param;
    assign out_block_o    = out_q.block;
    assign out_source_o   = src_q;
    assign busy_mask_o    = busy_q;
    assign inflight_o     = inflight_q;
    assign err_spurious_o = err_q;

endmodule

// File: tb/tb_source_a_arbiter.sv
// Directed bench for source_a_arbiter (N_REQ=8, MAX_OUT=4) plus an N_REQ=6 instance.
module tb_source_a_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic         reset;
    logic [7:0]   req_valid, req_ready, req_block, busy_mask;
    logic [103:0] req_tag;
    logic [79:0]  req_set;
    logic [23:0]  req_param;
    logic         out_valid, out_ready, out_block, grant_valid, err_spurious;
    logic [12:0]  out_tag;
    logic [9:0]   out_set;
    logic [2:0]   out_param, out_source, grant_source, inflight;

    logic [5:0]   req_valid6, req_ready6, req_block6, busy6;
    logic [77:0]  req_tag6;
    logic [59:0]  req_set6;
    logic [17:0]  req_param6;
    logic         out_valid6, out_ready6, out_block6, grant_valid6, err6;
    logic [12:0]  out_tag6;
    logic [9:0]   out_set6;
    logic [2:0]   out_param6, out_source6, grant_source6, inflight6;

    source_a_arbiter dut (
        .clock_i(clock), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_tag_i(req_tag),
        .req_set_i(req_set), .req_param_i(req_param), .req_block_i(req_block),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
        .out_set_o(out_set), .out_param_o(out_param), .out_block_o(out_block),
        .out_source_o(out_source), .grant_valid_i(grant_valid),
        .grant_source_i(grant_source), .busy_mask_o(busy_mask),
        .inflight_o(inflight), .err_spurious_o(err_spurious)
    );

    source_a_arbiter #(.N_REQ(6)) dut6 (
        .clock_i(clock), .reset_i(reset),
        .req_valid_i(req_valid6), .req_ready_o(req_ready6), .req_tag_i(req_tag6),
        .req_set_i(req_set6), .req_param_i(req_param6), .req_block_i(req_block6),
        .out_valid_o(out_valid6), .out_ready_i(out_ready6), .out_tag_o(out_tag6),
        .out_set_o(out_set6), .out_param_o(out_param6), .out_block_o(out_block6),
        .out_source_o(out_source6), .grant_valid_i(grant_valid6),
        .grant_source_i(grant_source6), .busy_mask_o(busy6),
        .inflight_o(inflight6), .err_spurious_o(err6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = '0; out_ready = 1'b0;
        grant_valid = 1'b0; grant_source = '0;
        tick(); tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req_tag = '0; req_set = '0; req_param = '0; req_block = '0;
        req_valid6 = '0; req_tag6 = '0; req_set6 = '0; req_param6 = '0; req_block6 = '0;
        out_ready6 = 1'b0; grant_valid6 = 1'b0; grant_source6 = '0;
        do_reset();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_ready", req_ready, 0);

        // 1: two requesters, lowest index first
        req_valid = 8'h05; out_ready = 1'b1; #1;
        chk("t1_rdy0", req_ready, 8'h01);
        tick();
        chk("t1_src0", out_source, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_rdy2", req_ready, 8'h04);
        tick();
        chk("t1_src2", out_source, 2);
        chk("t1_busy", busy_mask, 8'h05);
        chk("t1_inflight", inflight, 2);
        chk("t1_rdy_none", req_ready, 0);
        req_valid = '0;
        tick();
        chk("t1_release", out_valid, 0);

        // 2: credit limit
        do_reset();
        req_valid = 8'hFF; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t2_src%0d", k), out_source, k);
        end
        chk("t2_inflight", inflight, 4);
        chk("t2_busy", busy_mask, 8'h0F);
        chk("t2_rdy_lim", req_ready, 0);
        tick();
        chk("t2_valid_off", out_valid, 0);
        chk("t2_rdy_lim2", req_ready, 0);
        grant_valid = 1'b1; grant_source = 3'd1; #1;
        chk("t2_rdy_nobypass", req_ready, 0);
        tick();
        grant_valid = 1'b0; #1;
        chk("t2_inflight3", inflight, 3);
        chk("t2_busy_g1", busy_mask, 8'h0D);
        chk("t2_rdy4", req_ready, 8'h10);
        tick();
        chk("t2_src4", out_source, 4);
        chk("t2_inflight4", inflight, 4);
        chk("t2_busy4", busy_mask, 8'h1D);

        // 3: stall lock
        do_reset();
        req_tag[3*13 +: 13] = 13'h1ABC; req_set[3*10 +: 10] = 10'h155;
        req_param[3*3 +: 3] = 3'd2; req_block[3] = 1'b1;
        req_tag[5*13 +: 13] = 13'h0555;
        req_valid = 8'h08; out_ready = 1'b1;
        tick();
        chk("t3_src3", out_source, 3);
        req_valid = 8'h20; out_ready = 1'b0; req_tag[3*13 +: 13] = 13'h0111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t3_rdy_c%0d", k), req_ready, 0);
            chk($sformatf("t3_valid_c%0d", k), out_valid, 1);
            chk($sformatf("t3_src_c%0d", k), out_source, 3);
            chk($sformatf("t3_tag_c%0d", k), out_tag, 13'h1ABC);
            tick();
        end
        chk("t3_set", out_set, 10'h155);
        chk("t3_param", out_param, 2);
        chk("t3_block", out_block, 1);
        out_ready = 1'b1; #1;
        chk("t3_rdy5", req_ready, 8'h20);
        tick();
        chk("t3_src5", out_source, 5);
        chk("t3_tag5", out_tag, 13'h0555);
        chk("t3_block5", out_block, 0);

        // 4: simultaneous capture and grant
        do_reset();
        req_valid = 8'h0F; out_ready = 1'b1;
        repeat (4) tick();
        chk("t4_full", inflight, 4);
        req_valid = 8'h10; grant_valid = 1'b1; grant_source = 3'd1;
        tick();
        chk("t4_inflight_g1", inflight, 3);
        chk("t4_busy_g1", busy_mask, 8'h0D);
        grant_source = 3'd0; #1;
        chk("t4_rdy4", req_ready, 8'h10);
        tick();
        grant_valid = 1'b0;
        chk("t4_inflight_same", inflight, 3);
        chk("t4_busy_both", busy_mask, 8'h1C);
        chk("t4_src4", out_source, 4);
        chk("t4_err_none", err_spurious, 0);

        // 5: spurious grants (idle source, and out-of-range source on N_REQ=6)
        req_valid = '0;
        grant_valid = 1'b1; grant_source = 3'd6;
        grant_valid6 = 1'b1; grant_source6 = 3'd7; #1;
        chk("t5_err_notyet", err_spurious, 0);
        tick();
        grant_valid = 1'b0; grant_valid6 = 1'b0;
        chk("t5_err6", err_spurious, 1);
        chk("t5_err7_n6", err6, 1);
        chk("t5_busy", busy_mask, 8'h1C);
        chk("t5_inflight", inflight, 3);
        chk("t5_busy_n6", busy6, 0);
        chk("t5_inflight_n6", inflight6, 0);
        tick();
        chk("t5_err_off", err_spurious, 0);
        chk("t5_err_off_n6", err6, 0);
        grant_valid = 1'b1; grant_source = 3'd4;
        tick();
        grant_valid = 1'b0;
        tick();
        chk("t5_good_noerr", err_spurious, 0);
        chk("t5_good_busy", busy_mask, 8'h0C);
        chk("t5_good_inflight", inflight, 2);

        // 6: mid-operation reset
        do_reset();
        req_valid = 8'h07; out_ready = 1'b1;
        repeat (3) tick();
        chk("t6_inflight3", inflight, 3);
        chk("t6_valid", out_valid, 1);
        chk("t6_busy", busy_mask, 8'h07);
        reset = 1'b0; req_valid = 8'h2C; #1;
        chk("t6_rdy_in_rst", req_ready, 0);
        tick();
        chk("t6_valid0", out_valid, 0);
        chk("t6_busy0", busy_mask, 0);
        chk("t6_inflight0", inflight, 0);
        reset = 1'b1; #1;
        chk("t6_rdy_low", req_ready, 8'h04);
        tick();
        chk("t6_src2", out_source, 2);
        chk("t6_busy_new", busy_mask, 8'h04);
        chk("t6_inflight1", inflight, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
